score_note_scheduler: RTL and testbench
=======================================

// Module: score_note_scheduler
// PURPOSE
//  Places decoded notes onto the 4-staff score page.
//  Takes each (note, duration) event and gives it the next free slot:
//  4 staves x 16 slots, filled left-to-right, top-to-bottom.
//  Writes the note into the note-display buffer that the score renderer reads.
//  All buffer writes happen only in video blanking, so the page never tears.
//  Clears the page on reset, on request, and when the page overflows.
// PARAMETERS
//  NUM_SCORES       4   staves per page (power of 2)
//  SLOTS_PER_SCORE  16  note slots per staff (power of 2)
//  ADDR_W           6   log2(NUM_SCORES*SLOTS_PER_SCORE)
// PORTS
//  clk        in   1       system clock; single clock domain
//  reset      in   1       synchronous, active-high reset
//  note_dec   in   1       1-cycle pulse: note/duration valid
//  note       in   8       pitch code; 0 = rest (still occupies a slot)
//  duration   in   4       duration code; 0 = illegal
//  clear_req  in   1       1-cycle pulse: blank the page and restart at slot 0
//  blank      in   1       1 = outside active video; buffer writes allowed
//  busy       out  1       1 = not in IDLE; new notes are dropped
//  dropped    out  1       1-cycle pulse: a note_dec was rejected
//  wr_en      out  1       buffer write strobe
//  wr_addr    out  ADDR_W  buffer address = {staff, slot}
//  wr_data    out  13      {valid, duration[3:0], note[7:0]}; all-zero = empty slot
//  page_full  out  1       1 = slot NUM_SCORES*SLOTS_PER_SCORE-1 has been written
// BEHAVIOUR
//  Reset values
//   - wr_en=0, wr_addr=0, wr_data=0, dropped=0, page_full=0.
//   - ptr=0, pend=0; state=CLEAR, so busy=1 out of reset.
//  Slot pointer
//   - ptr[ADDR_W-1:0] points to the next slot to fill.
//   - staff = ptr[ADDR_W-1:4], slot = ptr[3:0].
//   - Increments by 1 after each note write. Wraps to 0 after slot 63.
//  Holding register
//   - One entry: {note, duration} plus a pend flag.
//  FSM states
//   - IDLE:
//     - clear_req=1 -> CLEAR. This has priority. If note_dec=1 and duration!=0
//       in the same cycle, capture the note and set pend=1.
//     - Otherwise, note_dec=1 with duration!=0 -> capture the note.
//       - page_full=1 -> set pend=1, go to CLEAR.
//       - page_full=0 -> go to WAIT_BLANK.
//     - note_dec=1 with duration=0 -> no capture; dropped=1 next cycle.
//   - WAIT_BLANK: go to WRITE on the first cycle blank=1.
//     A capture while blank=1 reaches WRITE in the next cycle.
//   - WRITE (exactly 1 cycle):
//     - wr_en=1, wr_addr=ptr, wr_data={1,duration,note}.
//     - ptr+=1; set page_full if ptr was 63.
//     - Clear pend; go to IDLE.
//   - CLEAR:
//     - Use an internal counter starting at 0.
//     - Each cycle with blank=1: wr_en=1, wr_addr=counter, wr_data=0, counter+=1.
//     - blank=0 pauses the clear (wr_en=0, counter holds).
//     - After address 63 is written: ptr=0, page_full=0.
//       - pend=1 -> WAIT_BLANK (pending note lands in slot 0).
//       - pend=0 -> IDLE.
//     - The clear takes 64 blank cycles minimum.
//  Busy / drop rules
//   - busy = (state != IDLE); busy is a registered output.
//   - note_dec=1 while busy=1 -> note ignored; dropped=1 next cycle.
//     pend and ptr are unchanged.
//   - clear_req while busy=1 is ignored, except in WAIT_BLANK/WRITE:
//     the current note still completes, then IDLE handles clear_req if it
//     is held. A clear_req pulse that is not held is lost.
//  Output timing
//   - wr_* are registered.
//   - wr_addr/wr_data are don't-care when wr_en=0; they hold their last value.
//  Reset mid-operation
//   - Abort any write; return to reset values.
//   - Restart the full CLEAR; the pending note is discarded.
// TESTING
//  1. Reset with blank=1: 64 writes addr 0..63, data 0 -> busy=0 at cycle 65.
//  2. blank=1, note_dec note=8'h3C dur=4
//     -> next cycle: wr_en=1, addr=0, data=13'h143C; then ptr=1.
//  3. blank=0 at the note_dec -> no wr_en until blank rises.
//     Then exactly 1 write to addr=ptr.
//  4. 64 notes, then note 8'h40 dur=2 -> page_full=1 after note 64.
//     Then 64 zero writes, then wr addr=0 data=13'h1240.
//  5. note_dec during busy, or dur=0 -> dropped pulse of 1 cycle.
//     No write; ptr unchanged.
//  6. Reset asserted halfway through CLEAR (counter=30)
//     -> clear restarts from addr 0; pend cleared.

Source files
------------

// File: rtl/score_note_scheduler.sv
// score_note_scheduler
//   Places decoded (note, duration) events into consecutive slots of a
//   4-staff x 16-slot score page held in the note-display buffer. Buffer
//   writes are issued only while blank=1 so the rendered page never tears.
//   The page is blanked on reset, on clear_req, and when a note arrives
//   after the last slot has been filled.
//
// Ports
//   clk        system clock
//   reset      synchronous active-high reset
//   note_dec   1-cycle pulse, note/duration valid
//   note       pitch code (0 = rest, still takes a slot)
//   duration   duration code (0 = illegal, note is dropped)
//   clear_req  1-cycle pulse, blank the page and restart at slot 0
//   blank      1 = outside active video, buffer writes allowed
//   busy       1 = not idle; new notes are dropped
//   dropped    1-cycle pulse, a note_dec was rejected
//   wr_en      buffer write strobe
//   wr_addr    buffer address {staff, slot}
//   wr_data    {valid, duration, note}; all-zero = empty slot
//   page_full  1 = last slot of the page has been written
//
// State table
//   S_IDLE       | waiting for a note or a clear request
//   S_WAIT_BLANK | note captured, waiting for blanking
//   S_WRITE      | note write strobe is on the bus (one cycle)
//   S_CLEAR      | zeroing the whole page, one slot per blank cycle

module score_note_scheduler #(
  parameter int NUM_SCORES      = 4,
  parameter int SLOTS_PER_SCORE = 16,
  parameter int ADDR_W          = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              note_dec,
  input  logic [7:0]        note,
  input  logic [3:0]        duration,
  input  logic              clear_req,
  input  logic              blank,
  output logic              busy,
  output logic              dropped,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [12:0]       wr_data,
  output logic              page_full
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SCORES * SLOTS_PER_SCORE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BLANK,
    S_WRITE,
    S_CLEAR
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] clr_cnt;
  logic              pend;
  logic [7:0]        hold_note;
  logic [3:0]        hold_dur;

  logic              valid_note;
  logic              capture;
  logic              set_pend;
  logic              note_wr;
  logic              clr_wr;
  logic              drop;
  logic [7:0]        src_note;
  logic [3:0]        src_dur;

  assign valid_note = note_dec && (duration != 4'd0);

  // A note captured while blank=1 is written straight from the inputs so
  // the strobe appears the cycle after note_dec; otherwise from the holding
  // register.
  assign src_note = capture ? note     : hold_note;
  assign src_dur  = capture ? duration : hold_dur;

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    set_pend   = 1'b0;
    note_wr    = 1'b0;
    clr_wr     = 1'b0;
    drop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_req) begin
          next_state = S_CLEAR;
          if (valid_note) begin
            capture  = 1'b1;
            set_pend = 1'b1;
          end else if (note_dec) begin
            drop = 1'b1;
          end
        end else if (valid_note) begin
          capture = 1'b1;
          if (page_full) begin
            set_pend   = 1'b1;
            next_state = S_CLEAR;
          end else if (blank) begin
            note_wr    = 1'b1;
            next_state = S_WRITE;
          end else begin
            next_state = S_WAIT_BLANK;
          end
        end else if (note_dec) begin
          drop = 1'b1;
        end
      end
      S_WAIT_BLANK: begin
        drop = note_dec;
        if (blank) begin
          note_wr    = 1'b1;
          next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        drop       = note_dec;
        next_state = S_IDLE;
      end
      S_CLEAR: begin
        drop = note_dec;
        if (blank) begin
          clr_wr = 1'b1;
          if (clr_cnt == LAST) begin
            next_state = pend ? S_WAIT_BLANK : S_IDLE;
          end
        end
      end
      default: next_state = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_CLEAR;
      busy      <= 1'b1;
      ptr       <= '0;
      clr_cnt   <= '0;
      pend      <= 1'b0;
      hold_note <= '0;
      hold_dur  <= '0;
      page_full <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      dropped   <= 1'b0;
    end else begin
      state   <= next_state;
      busy    <= (next_state != S_IDLE);
      dropped <= drop;
      wr_en   <= note_wr | clr_wr;

      if (capture) begin
        hold_note <= note;
        hold_dur  <= duration;
      end

      if (set_pend) begin
        pend <= 1'b1;
      end else if (state == S_WRITE) begin
        pend <= 1'b0;
      end

      if (note_wr) begin
        wr_addr <= ptr;
        wr_data <= {1'b1, src_dur, src_note};
        ptr     <= ptr + 1'b1;
        if (ptr == LAST) begin
          page_full <= 1'b1;
        end
      end

      // clr_cnt wraps to 0 after the last slot, so every clear starts at 0.
      if (clr_wr) begin
        wr_addr <= clr_cnt;
        wr_data <= '0;
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          ptr       <= '0;
          page_full <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_score_note_scheduler.sv
module tb_score_note_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        note_dec = 1'b0;
  logic [7:0]  note = '0;
  logic [3:0]  duration = '0;
  logic        clear_req = 1'b0;
  logic        blank = 1'b1;
  logic        busy;
  logic        dropped;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [12:0] wr_data;
  logic        page_full;

  int tests = 0;
  int fails = 0;

  logic [18:0] sb[$];
  logic [18:0] exp_w;
  logic [5:0]  exp_ptr = '0;

  score_note_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .note_dec  (note_dec),
    .note      (note),
    .duration  (duration),
    .clear_req (clear_req),
    .blank     (blank),
    .busy      (busy),
    .dropped   (dropped),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .page_full (page_full)
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write got addr=%0d data=%h, none expected", wr_addr, wr_data);
      end else begin
        exp_w = sb.pop_front();
        if ({wr_addr, wr_data} !== exp_w) begin
          fails++;
          $display("FAIL write got addr=%0d data=%h, want addr=%0d data=%h",
                   wr_addr, wr_data, exp_w[18:13], exp_w[12:0]);
        end
      end
    end
  end

  task automatic push_clear();
    for (int i = 0; i < 64; i++) sb.push_back({i[5:0], 13'h0000});
  endtask

  task automatic push_note(input logic [5:0] a, input logic [7:0] n, input logic [3:0] d);
    sb.push_back({a, 1'b1, d, n});
  endtask

  // Caller is in the posedge+1 phase; returns in the same phase.
  task automatic pulse(input logic [7:0] n, input logic [3:0] d, input logic clr);
    note_dec  = 1'b1;
    note      = n;
    duration  = d;
    clear_req = clr;
    @(posedge clk); #1;
    note_dec  = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1;
    blank = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({wr_en, busy, page_full, dropped, wr_addr, wr_data} !== {1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 13'd0}) begin
      fails++;
      $display("FAIL reset_values got en=%b busy=%b full=%b drop=%b addr=%0d data=%h, want 0 1 0 0 0 0",
               wr_en, busy, page_full, dropped, wr_addr, wr_data);
    end
    push_clear();
    reset = 1'b0;
    wait_idle(100, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL reset_clear got busy=%b pending=%0d, want idle with 0 pending", busy, sb.size());
    end
    tests++;
    if (page_full !== 1'b0) begin
      fails++;
      $display("FAIL reset_page_full got %b want 0", page_full);
    end
    exp_ptr = '0;
  endtask

  task automatic test_basic();
    bit ok;
    blank = 1'b1;
    push_note(exp_ptr, 8'h3C, 4'd4);
    pulse(8'h3C, 4'd4, 1'b0);
    tests++;
    if (wr_en !== 1'b1 || wr_data !== 13'h143C || wr_addr !== exp_ptr) begin
      fails++;
      $display("FAIL basic_latency got en=%b addr=%0d data=%h want 1 %0d 143c", wr_en, wr_addr, wr_data, exp_ptr);
    end
    exp_ptr++;
    wait_idle(10, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_wait_blank();
    bit ok;
    bit early;
    blank = 1'b0;
    pulse(8'h55, 4'd1, 1'b0);
    early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (wr_en !== 1'b0 || busy !== 1'b1) early = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (early) begin fails++; $display("FAIL wait_blank got write/idle before blank, want wait"); end
    push_note(exp_ptr, 8'h55, 4'd1);
    exp_ptr++;
    blank = 1'b1;
    wait_idle(10, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL wait_blank_done got busy=%b pending=%0d want idle 0", busy, sb.size()); end
  endtask

  task automatic test_drop();
    bit ok;
    blank = 1'b1;
    pulse(8'h11, 4'd0, 1'b0);
    tests++;
    if (dropped !== 1'b1) begin fails++; $display("FAIL drop_dur0 got %b want 1", dropped); end
    @(posedge clk); #1;
    tests++;
    if (dropped !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL drop_pulse_width got drop=%b busy=%b want 0 0", dropped, busy);
    end
    blank = 1'b0;
    pulse(8'h22, 4'd3, 1'b0);
    pulse(8'h33, 4'd5, 1'b0);
    tests++;
    if (dropped !== 1'b1) begin fails++; $display("FAIL drop_busy got %b want 1", dropped); end
    push_note(exp_ptr, 8'h22, 4'd3);
    exp_ptr++;
    blank = 1'b1;
    wait_idle(10, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL drop_done got busy=%b pending=%0d want idle 0", busy, sb.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_note(exp_ptr, 8'hA0 + 8'(i), 4'(i + 7));
      exp_ptr++;
      pulse(8'hA0 + 8'(i), 4'(i + 7), 1'b0);
      @(posedge clk); #1;
    end
    wait_idle(10, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL back_to_back got pending=%0d want 0", sb.size()); end
  endtask

  task automatic test_page_full();
    bit ok;
    bit slow;
    blank = 1'b1;
    slow = 1'b0;
    while (1) begin
      push_note(exp_ptr, {2'b01, exp_ptr}, 4'd1);
      pulse({2'b01, exp_ptr}, 4'd1, 1'b0);
      wait_idle(10, ok);
      if (!ok) slow = 1'b1;
      exp_ptr++;
      if (exp_ptr == 6'd0) break;
    end
    tests++;
    if (slow) begin fails++; $display("FAIL fill_page got stalled note write, want each write within 10 cycles"); end
    tests++;
    if (page_full !== 1'b1) begin fails++; $display("FAIL page_full_set got %b want 1", page_full); end
    push_clear();
    push_note(6'd0, 8'h40, 4'd2);
    pulse(8'h40, 4'd2, 1'b0);
    wait_idle(200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL overflow got busy=%b pending=%0d want idle 0", busy, sb.size()); end
    tests++;
    if (page_full !== 1'b0) begin fails++; $display("FAIL page_full_clr got %b want 0", page_full); end
    exp_ptr = 6'd1;
  endtask

  task automatic test_clear_req();
    bit ok;
    blank = 1'b1;
    push_clear();
    push_note(6'd0, 8'h00, 4'd9);
    pulse(8'h00, 4'd9, 1'b1);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL clear_req_busy got %b want 1", busy); end
    // Toggle blank a few times to exercise the clear pause.
    for (int i = 0; i < 20; i++) begin
      blank = i[0];
      @(posedge clk); #1;
    end
    blank = 1'b1;
    wait_idle(200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL clear_req got busy=%b pending=%0d want idle 0", busy, sb.size()); end
    exp_ptr = 6'd1;
  endtask

  task automatic test_reset_mid_clear();
    bit ok;
    int n;
    blank = 1'b1;
    push_clear();
    push_note(6'd0, 8'h77, 4'd3);
    pulse(8'h77, 4'd3, 1'b1);
    n = 0;
    while (sb.size() > 35 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (sb.size() != 35) begin fails++; $display("FAIL mid_clear_progress got pending=%0d want 35", sb.size()); end
    reset = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    tests++;
    if (wr_en !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset got en=%b busy=%b want 0 1", wr_en, busy);
    end
    push_clear();
    reset = 1'b0;
    wait_idle(100, ok);
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (!ok || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_restart got busy=%b pending=%0d want idle 0", busy, sb.size());
    end
    exp_ptr = 6'd0;
    push_note(exp_ptr, 8'h12, 4'd6);
    pulse(8'h12, 4'd6, 1'b0);
    exp_ptr++;
    wait_idle(10, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL ptr_after_reset got pending=%0d want 0", sb.size()); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_wait_blank();
    test_drop();
    test_back_to_back();
    test_page_full();
    test_clear_req();
    test_reset_mid_clear();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL leftover got %0d expected writes, want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
